pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_stage_valid.sv | 38 +++
 rtl/pipe_ctrl.sv | 132 +++++++++++++
 tb/tb_pipe_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and FSM encoding for the five-stage pipeline controller.
package pipe_pkg;

   localparam int unsigned CntWidth = 32;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StFlush = 2'd2
   } ctrl_state_e;

endpackage

// File: rtl/pipe_stage_valid.sv
// Valid flag and allow_in handshake for one pipeline stage (ID, EXE, MEM or WB).
module pipe_stage_valid (
   input  logic clk,
   input  logic resetn,
   input  logic prev_done,
   input  logic over,
   input  logic next_allow_in,
   input  logic flush,
   output logic valid,
   output logic allow_in,
   output logic done
);

   logic valid_q, valid_d;

   // allow_in depends only on valid/over, never on flush, so cancel has no path to it.
   assign allow_in = ~valid_q | (over & next_allow_in);
   assign done     = valid_q & over;
   assign valid    = valid_q;

   always_comb begin
      valid_d = valid_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (allow_in) begin
         valid_d = prev_done;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: valid/allow_in chain, latch enables, flush FSM
// and stall/retire counters.
module pipe_ctrl
   import pipe_pkg::*;
(
   input  logic                clk,
   input  logic                resetn,
   input  logic                IF_over,
   input  logic                ID_over,
   input  logic                EXE_over,
   input  logic                MEM_over,
   input  logic                WB_over,
   input  logic                cancel,
   output logic                IF_valid,
   output logic                ID_valid,
   output logic                EXE_valid,
   output logic                MEM_valid,
   output logic                WB_valid,
   output logic                IF_ID_en,
   output logic                ID_EXE_en,
   output logic                EXE_MEM_en,
   output logic                MEM_WB_en,
   output logic [CntWidth-1:0] stall_cnt,
   output logic [CntWidth-1:0] retire_cnt,
   output logic [1:0]          ctrl_state
);

   ctrl_state_e state_q, state_d;
   logic [CntWidth-1:0] stall_cnt_q, stall_cnt_d;
   logic [CntWidth-1:0] retire_cnt_q, retire_cnt_d;

   logic cancel_eff;
   logic if_done, id_done, exe_done, mem_done, wb_done;
   logic id_allow_in, exe_allow_in, mem_allow_in, wb_allow_in;

   // A cancel arriving while already flushing is dropped.
   assign cancel_eff = cancel & (state_q != StFlush);
   assign IF_valid   = (state_q == StRun);
   assign if_done    = IF_valid & IF_over;

   pipe_stage_valid u_id (
      .clk           (clk),
      .resetn        (resetn),
      .prev_done     (if_done),
      .over          (ID_over),
      .next_allow_in (exe_allow_in),
      .flush         (cancel_eff),
      .valid         (ID_valid),
      .allow_in      (id_allow_in),
      .done          (id_done)
   );

   pipe_stage_valid u_exe (
      .clk           (clk),
      .resetn        (resetn),
      .prev_done     (id_done),
      .over          (EXE_over),
      .next_allow_in (mem_allow_in),
      .flush         (cancel_eff),
      .valid         (EXE_valid),
      .allow_in      (exe_allow_in),
      .done          (exe_done)
   );

   pipe_stage_valid u_mem (
      .clk           (clk),
      .resetn        (resetn),
      .prev_done     (exe_done),
      .over          (MEM_over),
      .next_allow_in (wb_allow_in),
      .flush         (cancel_eff),
      .valid         (MEM_valid),
      .allow_in      (mem_allow_in),
      .done          (mem_done)
   );

   // WB is never flushed so the cancelling instruction itself retires.
   pipe_stage_valid u_wb (
      .clk           (clk),
      .resetn        (resetn),
      .prev_done     (mem_done),
      .over          (WB_over),
      .next_allow_in (1'b1),
      .flush         (1'b0),
      .valid         (WB_valid),
      .allow_in      (wb_allow_in),
      .done          (wb_done)
   );

   assign IF_ID_en   = if_done  & id_allow_in  & ~cancel_eff;
   assign ID_EXE_en  = id_done  & exe_allow_in & ~cancel_eff;
   assign EXE_MEM_en = exe_done & mem_allow_in & ~cancel_eff;
   assign MEM_WB_en  = mem_done & wb_allow_in;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  state_d = StRun;
         StRun:   if (cancel) state_d = StFlush;
         StFlush: state_d = StRun;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      retire_cnt_d = retire_cnt_q;
      if (ID_valid && !ID_over && !cancel_eff && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (wb_done) begin
         retire_cnt_d = retire_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= StIdle;
         stall_cnt_q  <= '0;
         retire_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         stall_cnt_q  <= stall_cnt_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign retire_cnt = retire_cnt_q;
   assign ctrl_state = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: an occupancy-based reference model predicts every
// cycle's outputs; a negedge monitor compares them against the design.
module tb_pipe_ctrl;

   logic        clk;
   logic        resetn;
   logic        IF_over, ID_over, EXE_over, MEM_over, WB_over, cancel;
   logic        IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid;
   logic        IF_ID_en, ID_EXE_en, EXE_MEM_en, MEM_WB_en;
   logic [31:0] stall_cnt, retire_cnt;
   logic [1:0]  ctrl_state;

   pipe_ctrl dut (
      .clk        (clk),
      .resetn     (resetn),
      .IF_over    (IF_over),
      .ID_over    (ID_over),
      .EXE_over   (EXE_over),
      .MEM_over   (MEM_over),
      .WB_over    (WB_over),
      .cancel     (cancel),
      .IF_valid   (IF_valid),
      .ID_valid   (ID_valid),
      .EXE_valid  (EXE_valid),
      .MEM_valid  (MEM_valid),
      .WB_valid   (WB_valid),
      .IF_ID_en   (IF_ID_en),
      .ID_EXE_en  (ID_EXE_en),
      .EXE_MEM_en (EXE_MEM_en),
      .MEM_WB_en  (MEM_WB_en),
      .stall_cnt  (stall_cnt),
      .retire_cnt (retire_cnt),
      .ctrl_state (ctrl_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  valids;  // bit i = stage i, 0 = IF .. 4 = WB
      logic [3:0]  ens;     // bit b = boundary b -> b+1
      logic [1:0]  st;
      logic [31:0] stall;
      logic [31:0] retire;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Reference model: occupancy of ID..WB, phase 0 idle / 1 run / 2 flush.
   bit          occ_m[5];
   int          phase_m;
   logic [31:0] stall_m, retire_m;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 5; i++) occ_m[i] = 1'b0;
      phase_m  = 0;
      stall_m  = '0;
      retire_m = '0;
   endtask

   // Drive one cycle's inputs, push the prediction, advance the model, stop at negedge+1.
   task automatic step(input logic [4:0] ov, input logic c);
      bit   occ[5];
      bit   room[5];
      bit   leave[5];
      bit   ce;
      exp_t e;
      {WB_over, MEM_over, EXE_over, ID_over, IF_over} = ov;
      cancel = c;
      occ[0] = (phase_m == 1);
      for (int i = 1; i < 5; i++) occ[i] = occ_m[i];
      ce = c && (phase_m != 2);
      for (int i = 4; i >= 0; i--) begin
         leave[i] = occ[i] && ov[i] && ((i == 4) || room[i+1]);
         room[i]  = !occ[i] || leave[i];
      end
      for (int i = 0; i < 5; i++) e.valids[i] = occ[i];
      for (int b = 0; b < 4; b++) e.ens[b] = leave[b] && ((b == 3) || !ce);
      e.st     = 2'(phase_m);
      e.stall  = stall_m;
      e.retire = retire_m;
      sb.push_back(e);
      for (int i = 1; i < 5; i++) occ_m[i] = room[i] ? leave[i-1] : occ[i];
      if (ce) for (int i = 1; i < 4; i++) occ_m[i] = 1'b0;
      if (occ[1] && !ov[1] && !ce && stall_m != 32'hFFFF_FFFF) stall_m++;
      if (occ[4] && ov[4]) retire_m++;
      case (phase_m)
         0: phase_m = 1;
         1: phase_m = c ? 2 : 1;
         default: phase_m = 1;
      endcase
      @(negedge clk);
      #1;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " valids"}, {27'd0, WB_valid, MEM_valid, EXE_valid, ID_valid, IF_valid}, 32'd0);
      check({tag, " enables"}, {28'd0, MEM_WB_en, EXE_MEM_en, ID_EXE_en, IF_ID_en}, 32'd0);
      check({tag, " state"}, {30'd0, ctrl_state}, 32'd0);
      check({tag, " stall_cnt"}, stall_cnt, 32'd0);
      check({tag, " retire_cnt"}, retire_cnt, 32'd0);
   endtask

   // Monitor: outputs are live every cycle, so each pending prediction is checked at negedge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("valids", {27'd0, WB_valid, MEM_valid, EXE_valid, ID_valid, IF_valid},
                  {27'd0, e.valids});
            check("enables", {28'd0, MEM_WB_en, EXE_MEM_en, ID_EXE_en, IF_ID_en}, {28'd0, e.ens});
            check("ctrl_state", {30'd0, ctrl_state}, {30'd0, e.st});
            check("stall_cnt", stall_cnt, e.stall);
            check("retire_cnt", retire_cnt, e.retire);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish, got running, expected done");
      $fatal(1);
   end

   initial begin
      logic [31:0] base;
      logic [4:0]  ov;
      resetn = 1'b0;
      {IF_over, ID_over, EXE_over, MEM_over, WB_over, cancel} = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check_all_zero("reset");
      adv();
      resetn = 1'b1;

      // Ramp-up with every stage finishing each cycle.
      for (int k = 1; k <= 8; k++) begin
         step(5'h1F, 1'b0);
         if (k == 1) check("c1 state", {30'd0, ctrl_state}, 32'd0);
         if (k == 1) check("c1 IF_valid", {31'd0, IF_valid}, 32'd0);
         if (k == 2) check("c2 IF_valid", {31'd0, IF_valid}, 32'd1);
         if (k == 5) check("c5 WB_valid", {31'd0, WB_valid}, 32'd0);
         if (k == 6) check("c6 WB_valid", {31'd0, WB_valid}, 32'd1);
         if (k == 6) check("c6 retire", retire_cnt, 32'd0);
         if (k == 7) check("c7 retire", retire_cnt, 32'd1);
         adv();
      end

      // ID hazard for three cycles.
      base = stall_m;
      for (int j = 0; j < 3; j++) begin
         step(5'b11101, 1'b0);
         check("stall IF_ID_en", {31'd0, IF_ID_en}, 32'd0);
         check("stall ID_EXE_en", {31'd0, ID_EXE_en}, 32'd0);
         if (j > 0) check("stall EXE bubble", {31'd0, EXE_valid}, 32'd0);
         adv();
      end
      step(5'h1F, 1'b0);
      check("post-stall EXE bubble", {31'd0, EXE_valid}, 32'd0);
      check("stall_cnt +3", stall_cnt, base + 32'd3);
      adv();
      repeat (4) begin step(5'h1F, 1'b0); adv(); end

      // Single-cycle cancel with a full pipeline.
      base = retire_m;
      step(5'h1F, 1'b1);
      adv();
      step(5'h1F, 1'b0);
      check("flush mid valids", {29'd0, MEM_valid, EXE_valid, ID_valid}, 32'd0);
      check("flush IF_valid", {31'd0, IF_valid}, 32'd0);
      check("flush state", {30'd0, ctrl_state}, 32'd2);
      check("flush retire", retire_cnt, base + 32'd1);
      adv();
      step(5'h1F, 1'b0);
      check("refetch IF_valid", {31'd0, IF_valid}, 32'd1);
      adv();
      repeat (5) begin step(5'h1F, 1'b0); adv(); end

      // Cancel coinciding with an ID stall.
      base = stall_m;
      step(5'b11101, 1'b1);
      adv();
      step(5'h1F, 1'b0);
      check("cancel+stall ID_valid", {31'd0, ID_valid}, 32'd0);
      check("cancel+stall stall_cnt", stall_cnt, base);
      adv();
      repeat (6) begin step(5'h1F, 1'b0); adv(); end

      // Asynchronous reset mid-stream.
      step(5'h1F, 1'b0);
      resetn = 1'b0;
      #1;
      check_all_zero("async reset");
      model_reset();
      adv();
      resetn = 1'b1;
      repeat (8) begin step(5'h1F, 1'b0); adv(); end

      // Counter boundaries via preload.
      force dut.stall_cnt_q = 32'hFFFF_FFFD;
      #1;
      release dut.stall_cnt_q;
      stall_m = 32'hFFFF_FFFD;
      repeat (5) begin step(5'b11101, 1'b0); adv(); end
      step(5'h1F, 1'b0);
      check("stall saturate", stall_cnt, 32'hFFFF_FFFF);
      adv();
      repeat (5) begin step(5'h1F, 1'b0); adv(); end
      force dut.retire_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.retire_cnt_q;
      retire_m = 32'hFFFF_FFFF;
      step(5'h1F, 1'b0);
      adv();
      step(5'h1F, 1'b0);
      check("retire wrap", retire_cnt, 32'd0);
      adv();

      // Randomized traffic.
      for (int n = 0; n < 2500; n++) begin
         for (int i = 0; i < 5; i++) ov[i] = ($urandom_range(0, 3) != 0);
         step(ov, ($urandom_range(0, 19) == 0));
         adv();
      end

      @(negedge clk);
      #1;
      check("scoreboard drained", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
